// File: rtl/jb_prach_tdm_sched_if.sv
// rtl/jb_prach_tdm_sched_if.sv - control, request and slot-output bundle for the PRACH TDM slot scheduler
interface jb_prach_tdm_sched_if #(
    parameter int N_ANTENNAS = 4,
    parameter int USR_ID_BW  = 2
);
    logic                  clk_en;
    logic [N_ANTENNAS-1:0] cfg_ant_mask;
    logic                  cfg_start;
    logic                  cfg_stop;
    logic                  sync_in;
    logic [N_ANTENNAS-1:0] req_in;
    logic                  ovf_clr;
    logic [USR_ID_BW-1:0]  slot_sel;
    logic                  slot_valid;
    logic                  round_start;
    logic                  busy;
    logic [1:0]            state_o;
    logic [N_ANTENNAS-1:0] ovf_sticky;
    logic                  align_err;

    modport master (
        output clk_en, cfg_ant_mask, cfg_start, cfg_stop, sync_in, req_in, ovf_clr,
        input  slot_sel, slot_valid, round_start, busy, state_o, ovf_sticky, align_err
    );

    modport slave (
        input  clk_en, cfg_ant_mask, cfg_start, cfg_stop, sync_in, req_in, ovf_clr,
        output slot_sel, slot_valid, round_start, busy, state_o, ovf_sticky, align_err
    );
endinterface

// File: rtl/jb_prach_tdm_sched.sv
// rtl/jb_prach_tdm_sched.sv - PRACH parallel-to-serial TDM slot scheduler with start/stop sequencing
module jb_prach_tdm_sched #(
    parameter int N_ANTENNAS = 4,
    parameter int USR_ID_BW  = 2
) (
    input  logic                 clk_4x,
    input  logic                 reset_4x,
    jb_prach_tdm_sched_if.slave  sif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam logic [USR_ID_BW-1:0] LAST_SLOT = USR_ID_BW'(N_ANTENNAS - 1);

    state_t                state, state_nxt;
    logic [USR_ID_BW-1:0]  slot_cnt, slot_nxt, slot_inc;
    logic [N_ANTENNAS-1:0] pending, pending_nxt;
    logic [N_ANTENNAS-1:0] mask_q, mask_eff;
    logic [N_ANTENNAS-1:0] served_onehot, ovf_set;
    logic                  serve, sync_run, align_hit;

    logic [USR_ID_BW-1:0]  slot_sel_q;
    logic                  slot_valid_q, round_start_q, align_err_q;
    logic [N_ANTENNAS-1:0] ovf_q;

    always_ff @(posedge clk_4x or posedge reset_4x) begin
        if (reset_4x) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        serve     = 1'b0;
        sync_run  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sif.cfg_start) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                // a start pulse coinciding with sync masks that sync
                if (sif.cfg_stop)                        state_nxt = ST_IDLE;
                else if (sif.sync_in && !sif.cfg_start)  state_nxt = ST_RUN;
            end
            ST_RUN: begin
                serve    = sif.clk_en;
                sync_run = sif.sync_in;
                if (sif.cfg_stop) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                serve = sif.clk_en;
                if (sif.clk_en && slot_cnt == LAST_SLOT) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        slot_inc = (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + 1'b1;
        slot_nxt = serve ? slot_inc : slot_cnt;
        if (sync_run || state == ST_IDLE || state == ST_ARMED) slot_nxt = '0;

        served_onehot = '0;
        if (serve) served_onehot[slot_cnt] = 1'b1;

        // slot 0 opens a round, so it already sees the freshly sampled mask
        mask_eff = (slot_cnt == '0) ? sif.cfg_ant_mask : mask_q;

        if (state == ST_IDLE) begin
            ovf_set     = '0;
            pending_nxt = '0;
        end else begin
            ovf_set     = sif.req_in & pending & ~served_onehot;
            pending_nxt = (pending & ~served_onehot) | sif.req_in;
        end

        // aligned only when the lane would naturally be at slot 0 next anyway
        align_hit = sync_run && (serve ? (slot_cnt != LAST_SLOT) : (slot_cnt != '0));
    end

    always_ff @(posedge clk_4x or posedge reset_4x) begin
        if (reset_4x) begin
            slot_cnt      <= '0;
            pending       <= '0;
            mask_q        <= '0;
            slot_sel_q    <= '0;
            slot_valid_q  <= 1'b0;
            round_start_q <= 1'b0;
            ovf_q         <= '0;
            align_err_q   <= 1'b0;
        end else begin
            slot_cnt <= slot_nxt;
            pending  <= pending_nxt;
            if (serve && slot_cnt == '0) mask_q <= sif.cfg_ant_mask;
            if (serve) begin
                slot_sel_q    <= slot_cnt;
                slot_valid_q  <= pending[slot_cnt] & mask_eff[slot_cnt];
                round_start_q <= (slot_cnt == '0);
            end else begin
                slot_valid_q  <= 1'b0;
                round_start_q <= 1'b0;
            end
            if (sif.ovf_clr) begin
                ovf_q       <= '0;
                align_err_q <= 1'b0;
            end else begin
                ovf_q <= ovf_q | ovf_set;
                if (align_hit) align_err_q <= 1'b1;
            end
        end
    end

    assign sif.slot_sel    = slot_sel_q;
    assign sif.slot_valid  = slot_valid_q;
    assign sif.round_start = round_start_q;
    assign sif.busy        = (state != ST_IDLE);
    assign sif.state_o     = state;
    assign sif.ovf_sticky  = ovf_q;
    assign sif.align_err   = align_err_q;
endmodule

// File: tb/tb_jb_prach_tdm_sched.sv
// tb/tb_jb_prach_tdm_sched.sv - vector table, corner sequences and randomized model check for jb_prach_tdm_sched
module tb_jb_prach_tdm_sched;
    localparam int N = 4;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic       start;
        logic       stop;
        logic       sync;
        logic [3:0] req;
        logic       clr;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [1:0] st;
        logic [1:0] sel;
        logic       v;
        logic       rs;
    } vec_t;

    logic clk_4x = 1'b0;
    logic reset_4x = 1'b1;
    always #5 clk_4x = ~clk_4x;

    jb_prach_tdm_sched_if #(.N_ANTENNAS(N), .USR_ID_BW(2)) sif ();

    jb_prach_tdm_sched #(.N_ANTENNAS(N), .USR_ID_BW(2)) dut (
        .clk_4x   (clk_4x),
        .reset_4x (reset_4x),
        .sif      (sif)
    );

    int errors = 0;
    int checks = 0;

    // reference model: a round-robin lane over N antennas with sample-pending bookkeeping
    int       m_state;
    int       m_slot;
    bit [3:0] m_pend, m_mask, m_ovf;
    bit       m_aerr;
    int       e_sel;
    bit       e_valid, e_rs;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic en, input logic [3:0] mask, input logic start,
                                 input logic stop, input logic sync, input logic [3:0] req,
                                 input logic clr);
        stim_t s;
        s.en = en; s.mask = mask; s.start = start; s.stop = stop;
        s.sync = sync; s.req = req; s.clr = clr;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic [1:0] st, input logic [1:0] sel,
                                 input logic v, input logic rs);
        vec_t r;
        r.s = s; r.st = st; r.sel = sel; r.v = v; r.rs = rs;
        return r;
    endfunction

    function automatic logic [15:0] dut_pack();
        return {3'b000, sif.state_o, sif.busy, sif.slot_sel, sif.slot_valid,
                sif.round_start, sif.ovf_sticky, sif.align_err};
    endfunction

    function automatic logic [15:0] model_pack();
        logic [1:0] st, sl;
        st = 2'(m_state);
        sl = 2'(e_sel);
        return {3'b000, st, (m_state != 0), sl, e_valid, e_rs, m_ovf, m_aerr};
    endfunction

    task automatic model_reset();
        m_state = 0; m_slot = 0; m_pend = '0; m_mask = '0; m_ovf = '0; m_aerr = 0;
        e_sel = 0; e_valid = 0; e_rs = 0;
    endtask

    task automatic model_step(input stim_t s);
        bit       serving;
        int       k, nat, nst;
        bit [3:0] np, novf;
        serving = (m_state >= 2) && s.en;
        k = m_slot;
        nst = m_state;
        np = m_pend;
        novf = m_ovf;
        e_valid = 0;
        e_rs = 0;
        if (m_state == 0) begin
            np = '0;
            m_slot = 0;
            if (s.start) nst = 1;
        end else begin
            for (int i = 0; i < N; i++)
                if (s.req[i] && m_pend[i] && !(serving && k == i)) novf[i] = 1;
            np = m_pend | s.req;
            if (m_state == 1) begin
                m_slot = 0;
                if (s.stop) nst = 0;
                else if (s.sync && !s.start) nst = 2;
            end else begin
                if (serving) begin
                    if (k == 0) m_mask = s.mask;
                    e_sel = k;
                    e_valid = m_pend[k] & m_mask[k];
                    e_rs = (k == 0);
                    np[k] = s.req[k];
                end
                nat = serving ? (k + 1) % N : k;
                m_slot = nat;
                if (m_state == 2) begin
                    if (s.sync) begin
                        if (nat != 0) m_aerr = 1;
                        m_slot = 0;
                    end
                    if (s.stop) nst = 3;
                end else if (serving && k == N - 1) begin
                    nst = 0;
                end
            end
        end
        if (s.clr) begin
            novf = '0;
            m_aerr = 0;
        end
        m_pend = np;
        m_ovf = novf;
        m_state = nst;
    endtask

    task automatic apply(input stim_t s);
        sif.clk_en = s.en;
        sif.cfg_ant_mask = s.mask;
        sif.cfg_start = s.start;
        sif.cfg_stop = s.stop;
        sif.sync_in = s.sync;
        sif.req_in = s.req;
        sif.ovf_clr = s.clr;
    endtask

    task automatic cycle(input stim_t s);
        apply(s);
        @(posedge clk_4x);
        model_step(s);
        #1;
        check("model", dut_pack(), model_pack());
    endtask

    vec_t     tbl[16];
    stim_t    idle_s;
    int       gap_valid;
    int       guard;

    initial begin
        idle_s = mk(0, 4'hF, 0, 0, 0, 4'h0, 0);
        apply(idle_s);
        model_reset();
        repeat (2) @(posedge clk_4x);
        #1;
        check("reset_state", dut_pack(), 16'h0000);
        reset_4x = 1'b0;

        // basic run then a 4'b1010 mask taking effect at the round boundary
        tbl[0]  = mkv(mk(0, 4'hF, 1, 0, 0, 4'h0, 0), 2'b01, 2'd0, 0, 0);
        tbl[1]  = mkv(mk(0, 4'hF, 0, 0, 0, 4'hF, 0), 2'b01, 2'd0, 0, 0);
        tbl[2]  = mkv(mk(0, 4'hF, 0, 0, 1, 4'h0, 0), 2'b10, 2'd0, 0, 0);
        tbl[3]  = mkv(mk(1, 4'hF, 0, 0, 0, 4'h0, 0), 2'b10, 2'd0, 1, 1);
        tbl[4]  = mkv(mk(1, 4'hF, 0, 0, 0, 4'h0, 0), 2'b10, 2'd1, 1, 0);
        tbl[5]  = mkv(mk(1, 4'hF, 0, 0, 0, 4'h0, 0), 2'b10, 2'd2, 1, 0);
        tbl[6]  = mkv(mk(1, 4'hF, 0, 0, 0, 4'hF, 0), 2'b10, 2'd3, 1, 0);
        tbl[7]  = mkv(mk(1, 4'hF, 0, 0, 0, 4'h0, 0), 2'b10, 2'd0, 1, 1);
        tbl[8]  = mkv(mk(1, 4'hF, 0, 0, 0, 4'h0, 0), 2'b10, 2'd1, 1, 0);
        tbl[9]  = mkv(mk(1, 4'hF, 0, 0, 0, 4'h0, 0), 2'b10, 2'd2, 1, 0);
        tbl[10] = mkv(mk(1, 4'hF, 0, 0, 0, 4'hF, 0), 2'b10, 2'd3, 1, 0);
        tbl[11] = mkv(mk(1, 4'hA, 0, 0, 0, 4'h0, 0), 2'b10, 2'd0, 0, 1);
        tbl[12] = mkv(mk(1, 4'hA, 0, 0, 0, 4'h0, 0), 2'b10, 2'd1, 1, 0);
        tbl[13] = mkv(mk(1, 4'hA, 0, 0, 0, 4'h0, 0), 2'b10, 2'd2, 0, 0);
        tbl[14] = mkv(mk(1, 4'hA, 0, 0, 0, 4'hF, 0), 2'b10, 2'd3, 1, 0);
        tbl[15] = mkv(mk(0, 4'hA, 0, 0, 0, 4'h0, 0), 2'b10, 2'd3, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].s);
            check($sformatf("vec%0d", i),
                  {10'd0, sif.state_o, sif.slot_sel, sif.slot_valid, sif.round_start},
                  {10'd0, tbl[i].st, tbl[i].sel, tbl[i].v, tbl[i].rs});
        end

        // drain pending by serving slots 0..2, then double request on antenna 2
        for (int i = 0; i < 3; i++) cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
        cycle(mk(0, 4'hF, 0, 0, 0, 4'h4, 0));
        check("ovf_first_req", {12'd0, sif.ovf_sticky}, 16'h0000);
        cycle(mk(0, 4'hF, 0, 0, 0, 4'h4, 0));
        check("ovf_second_req", {12'd0, sif.ovf_sticky}, 16'h0004);
        cycle(mk(0, 4'hF, 0, 0, 0, 4'h0, 1));
        check("ovf_clr", {12'd0, sif.ovf_sticky}, 16'h0000);

        // one enable in four: two advances over eight cycles, nothing on gap cycles
        gap_valid = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(mk((i % 4) == 0, 4'hF, 0, 0, 0, 4'hF & {4{(i % 4) == 1}}, 0));
            if ((i % 4) != 0 && (sif.slot_valid || sif.round_start)) gap_valid++;
        end
        check("gap_quiet", 16'(gap_valid), 16'd0);
        check("gap_slot_sel", {14'd0, sif.slot_sel}, 16'd0);
        cycle(mk(0, 4'hF, 0, 0, 0, 4'h0, 1));

        // sync mid-round
        guard = 0;
        while (m_slot != 1 && guard < 8) begin
            cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
            guard++;
        end
        check("reach_slot1_a", 16'(m_slot), 16'd1);
        cycle(mk(0, 4'hF, 0, 0, 1, 4'h0, 0));
        check("align_err_set", {15'd0, sif.align_err}, 16'd1);
        cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
        check("resync_slot0", {14'd0, sif.slot_sel, sif.round_start}, {14'd0, 2'd0, 1'b1});
        cycle(mk(0, 4'hF, 0, 0, 0, 4'h0, 1));
        check("align_err_clr", {15'd0, sif.align_err}, 16'd0);

        // graceful stop while slot 1 is served
        guard = 0;
        while (m_slot != 1 && guard < 8) begin
            cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
            guard++;
        end
        cycle(mk(1, 4'hF, 0, 1, 0, 4'h0, 0));
        check("stop_drain", {12'd0, sif.state_o, sif.slot_sel}, {12'd0, 2'b11, 2'd1});
        cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
        check("drain_slot2", {12'd0, sif.state_o, sif.slot_sel}, {12'd0, 2'b11, 2'd2});
        cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
        check("drain_end", {11'd0, sif.state_o, sif.busy, sif.slot_sel}, {11'd0, 2'b00, 1'b0, 2'd3});

        // start and sync together in ARMED: sync is dropped
        cycle(mk(0, 4'hF, 1, 0, 0, 4'h0, 0));
        cycle(mk(0, 4'hF, 1, 0, 1, 4'h0, 0));
        check("start_masks_sync", {14'd0, sif.state_o}, 16'd1);
        cycle(mk(0, 4'hF, 0, 0, 1, 4'hF, 0));
        check("sync_to_run", {14'd0, sif.state_o}, 16'd2);

        // asynchronous reset mid-round
        cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
        cycle(mk(1, 4'hF, 0, 0, 0, 4'h0, 0));
        reset_4x = 1'b1;
        #1;
        check("async_reset", dut_pack(), 16'h0000);
        model_reset();
        @(posedge clk_4x);
        #1;
        reset_4x = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            stim_t s;
            s.en    = ($urandom % 4) != 0;
            s.mask  = 4'($urandom);
            s.start = ($urandom % 8) == 0;
            s.stop  = ($urandom % 24) == 0;
            s.sync  = ($urandom % 10) == 0;
            s.req   = 4'($urandom) & 4'($urandom);
            s.clr   = ($urandom % 20) == 0;
            cycle(s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
